// File: rtl/float_to_double_if.sv
// Request/result bundle for the single-to-double widening converter.
interface float_to_double_if;
    logic        start;
    logic [31:0] float;
    logic [63:0] double;
    logic        done;
    logic        busy;
    logic        nan_exception;
    logic        subnormal_flag;

    modport master (output start, float,
                    input  double, done, busy, nan_exception, subnormal_flag);
    modport slave  (input  start, float,
                    output double, done, busy, nan_exception, subnormal_flag);
endinterface

// File: rtl/float_to_double.sv
// IEEE 754 single -> double widening converter, start/done handshake.
// Define F2D_SUBNORMAL_EN for exact subnormal normalization; otherwise subnormals flush to zero.
module float_to_double (
    input  logic              clk,
    input  logic              reset,
    float_to_double_if.slave  bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CHECK = 2'd1;
`ifdef F2D_SUBNORMAL_EN
    localparam logic [1:0] NORM  = 2'd2;
`endif
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]  state;
    logic [31:0] op;
    logic [63:0] dbl;
    logic        nan_q;
    logic        sub_q;
`ifdef F2D_SUBNORMAL_EN
    logic [23:0] m;
    logic [10:0] x;
`endif

    logic        s;
    logic [7:0]  e;
    logic [22:0] f;
    assign s = op[31];
    assign e = op[30:23];
    assign f = op[22:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            op    <= '0;
            dbl   <= '0;
            nan_q <= 1'b0;
            sub_q <= 1'b0;
`ifdef F2D_SUBNORMAL_EN
            m     <= '0;
            x     <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        op    <= bus.float;
                        nan_q <= 1'b0;
                        sub_q <= 1'b0;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    state <= DONE;
                    if (e == 8'hFF) begin
                        if (f == 23'd0) begin
                            dbl <= {s, 11'h7FF, 52'd0};
                        end else begin
                            // Quieting sets the top fraction bit; the payload is kept.
                            dbl   <= {s, 11'h7FF, 1'b1, f[21:0], 29'd0};
                            nan_q <= ~f[22];
                        end
                    end else if (e == 8'h00) begin
                        if (f == 23'd0) begin
                            dbl <= {s, 63'd0};
                        end else begin
                            sub_q <= 1'b1;
`ifdef F2D_SUBNORMAL_EN
                            m     <= {1'b0, f};
                            x     <= 11'd897;
                            state <= NORM;
`else
                            dbl   <= {s, 63'd0};
`endif
                        end
                    end else begin
                        dbl <= {s, {3'd0, e} + 11'd896, f, 29'd0};
                    end
                end
`ifdef F2D_SUBNORMAL_EN
                NORM: begin
                    // One bit per cycle until the hidden bit reaches m[23].
                    if (m[23]) begin
                        dbl   <= {s, x, m[22:0], 29'd0};
                        state <= DONE;
                    end else begin
                        m <= {m[22:0], 1'b0};
                        x <= x - 11'd1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.double         = dbl;
    assign bus.done           = (state == DONE);
`ifdef F2D_SUBNORMAL_EN
    assign bus.busy           = (state == CHECK) || (state == NORM);
`else
    assign bus.busy           = (state == CHECK);
`endif
    assign bus.nan_exception  = nan_q;
    assign bus.subnormal_flag = sub_q;
endmodule

// File: tb/tb_float_to_double.sv
// Directed checks for float_to_double; expected values worked out by hand from the IEEE encodings.
module tb_float_to_double;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    float_to_double_if bus();
    float_to_double dut (.clk(clk), .reset(reset), .bus(bus.slave));

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // exp_edges counts clock edges after the accepting edge until done is seen.
    task automatic run(input string tag, input logic [31:0] in, input logic [63:0] exp,
                       input logic exp_nan, input logic exp_sub, input int exp_edges);
        int n;
        n = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.float = in;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.float = $urandom;
        chk({tag, "_done_drop"}, 64'(bus.done), 64'd0);
        chk({tag, "_busy"},      64'(bus.busy), 64'd1);
        while (bus.done !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_edges"},  64'(n), 64'(exp_edges));
        chk({tag, "_double"}, bus.double, exp);
        chk({tag, "_nan"},    64'(bus.nan_exception), 64'(exp_nan));
        chk({tag, "_sub"},    64'(bus.subnormal_flag), 64'(exp_sub));
    endtask

    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.float = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_double", bus.double, 64'd0);
        chk("rst_done",   64'(bus.done), 64'd0);
        chk("rst_busy",   64'(bus.busy), 64'd0);
        chk("rst_nan",    64'(bus.nan_exception), 64'd0);
        chk("rst_sub",    64'(bus.subnormal_flag), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        run("one",     32'h3F800000, 64'h3FF0000000000000, 1'b0, 1'b0, 1);
        run("neg_inf", 32'hFF800000, 64'hFFF0000000000000, 1'b0, 1'b0, 1);
        run("neg_zero",32'h80000000, 64'h8000000000000000, 1'b0, 1'b0, 1);
        run("snan",    32'h7F800001, 64'h7FF8000020000000, 1'b1, 1'b0, 1);
        run("qnan",    32'h7FC00000, 64'h7FF8000000000000, 1'b0, 1'b0, 1);
        run("neg_pi",  32'hC0490FDB, 64'hC00921FB60000000, 1'b0, 1'b0, 1);
        run("max_fin", 32'h7F7FFFFF, 64'h47EFFFFFE0000000, 1'b0, 1'b0, 1);
        run("min_norm",32'h00800000, 64'h3810000000000000, 1'b0, 1'b0, 1);
`ifdef F2D_SUBNORMAL_EN
        run("sub_p0",  32'h00000001, 64'h36A0000000000000, 1'b0, 1'b1, 25);
        run("sub_p22", 32'h00400000, 64'h3800000000000000, 1'b0, 1'b1, 3);
        run("sub_neg", 32'h80000001, 64'hB6A0000000000000, 1'b0, 1'b1, 25);
`else
        run("sub_p0",  32'h00000001, 64'h0000000000000000, 1'b0, 1'b1, 1);
        run("sub_p22", 32'h00400000, 64'h0000000000000000, 1'b0, 1'b1, 1);
        run("sub_neg", 32'h80000001, 64'h8000000000000000, 1'b0, 1'b1, 1);
`endif

        // Asynchronous reset in the middle of a subnormal conversion.
        @(negedge clk);
        bus.start = 1'b1;
        bus.float = 32'h00000001;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("mid_rst_double", bus.double, 64'd0);
        chk("mid_rst_done",   64'(bus.done), 64'd0);
        chk("mid_rst_busy",   64'(bus.busy), 64'd0);
        chk("mid_rst_nan",    64'(bus.nan_exception), 64'd0);
        chk("mid_rst_sub",    64'(bus.subnormal_flag), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        run("post_rst", 32'h3F800000, 64'h3FF0000000000000, 1'b0, 1'b0, 1);

        // start held high during CHECK must not replace the operand in flight.
        @(negedge clk);
        bus.start = 1'b1;
        bus.float = 32'h3F800000;
        @(posedge clk);
        #1;
        bus.float = 32'hFF800000;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("busy_ign_done",   64'(bus.done), 64'd1);
        chk("busy_ign_double", bus.double, 64'h3FF0000000000000);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_done",   64'(bus.done), 64'd1);
        chk("hold_double", bus.double, 64'h3FF0000000000000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
